// File: rtl/alu_md_iter_if.sv
// Execute-stage ALU handshake bundle: operation offer on the input side,
// registered result with valid/ready on the output side.
interface alu_md_iter_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [18:0]     alu_op;
   logic [XLEN-1:0] alu_src1;
   logic [XLEN-1:0] alu_src2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            busy;

   modport master (
      output in_valid, alu_op, alu_src1, alu_src2, out_ready,
      input  in_ready, out_valid, alu_result, busy
   );

   modport slave (
      input  in_valid, alu_op, alu_src1, alu_src2, out_ready,
      output in_ready, out_valid, alu_result, busy
   );
endinterface

// File: rtl/alu_md_iter.sv
// Registered-output execute ALU with an optional iterative multiply/divide path.
// Define ALU_MD_ITER_MD_EN to build the mul/div path; otherwise ops 12-18 are ignored.
module alu_md_iter #(
   parameter int XLEN = 32
) (
   input logic         clk,
   input logic         resetn,
   input logic         flush,
   alu_md_iter_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_d, state_q;
   logic [XLEN-1:0] res_d, res_q;

   logic [XLEN-1:0] a, b;
   logic [18:0]     op;
   logic [SHW-1:0]  sh;
   logic            accept;
   logic [XLEN-1:0] base_res;

   assign a      = bus.alu_src1;
   assign b      = bus.alu_src2;
   assign op     = bus.alu_op;
   assign sh     = b[SHW-1:0];
   assign accept = bus.in_valid & bus.in_ready;

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.alu_result = res_q;
   assign bus.busy       = (state_q == S_BUSY);

   // Several base bits at once simply OR their results together.
   always_comb begin
      base_res = '0;
      if (op[0])  base_res |= a + b;
      if (op[1])  base_res |= a - b;
      if (op[2])  base_res |= {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      if (op[3])  base_res |= {{(XLEN-1){1'b0}}, (a < b)};
      if (op[4])  base_res |= a & b;
      if (op[5])  base_res |= ~(a | b);
      if (op[6])  base_res |= a | b;
      if (op[7])  base_res |= a ^ b;
      if (op[8])  base_res |= a << sh;
      if (op[9])  base_res |= a >> sh;
      if (op[10]) base_res |= unsigned'($signed(a) >>> sh);
      if (op[11]) base_res |= b;
   end

`ifdef ALU_MD_ITER_MD_EN
   localparam int CW = SHW + 1;

   logic              md_req, md_is_mul, md_signed, sa, sb, neg_init;
   logic [2:0]        md_sel;
   logic [XLEN-1:0]   ma, mb;
   logic [CW-1:0]     cnt_d, cnt_q;
   logic [2:0]        sel_d, sel_q;
   logic              neg_d, neg_q;
   logic [2*XLEN-1:0] acc_d, acc_q, acc_nx;
   logic [XLEN-1:0]   opb_d, opb_q;
   logic [XLEN:0]     mul_sum, div_t;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, md_res;

   // md_sel: 0 mul, 1 mulh, 2 mulhu, 3 div, 4 mod, 5 divu, 6 modu; lowest bit wins.
   assign md_req = |op[18:12];
   always_comb begin
      md_sel = '0;
      for (int i = 6; i >= 0; i--)
         if (op[12+i]) md_sel = 3'(i);
   end

   assign md_is_mul = (md_sel <= 3'd2);
   assign md_signed = (md_sel == 3'd0) | (md_sel == 3'd1) | (md_sel == 3'd3) | (md_sel == 3'd4);
   assign sa        = md_signed & a[XLEN-1];
   assign sb        = md_signed & b[XLEN-1];
   assign ma        = sa ? -a : a;
   assign mb        = sb ? -b : b;

   // Zero divisor keeps the quotient all-ones; remainder follows the dividend's sign.
   assign neg_init = md_is_mul ? (sa ^ sb) :
                     ((md_sel == 3'd3) || (md_sel == 3'd5)) ? ((sa ^ sb) & (|b)) : sa;

   // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div.
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign div_t   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_ge  = (div_t >= {1'b0, opb_q});
   assign div_rem = div_ge ? (div_t[XLEN-1:0] - opb_q) : div_t[XLEN-1:0];
   assign acc_nx  = (sel_q <= 3'd2) ? {mul_sum, acc_q[XLEN-1:1]}
                                    : {div_rem, acc_q[XLEN-2:0], div_ge};

   assign prod_fix = neg_q ? -acc_nx : acc_nx;
   assign quo_fix  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
   assign rem_fix  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

   always_comb begin
      case (sel_q)
         3'd0:       md_res = prod_fix[XLEN-1:0];
         3'd1, 3'd2: md_res = prod_fix[2*XLEN-1:XLEN];
         3'd3, 3'd5: md_res = quo_fix;
         default:    md_res = rem_fix;
      endcase
   end
`else
   logic unused_md_bits;
   assign unused_md_bits = ^op[18:12];
`endif

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
`ifdef ALU_MD_ITER_MD_EN
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
`endif
      if (flush) begin
         state_d = S_IDLE;
`ifdef ALU_MD_ITER_MD_EN
         cnt_d   = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
`ifdef ALU_MD_ITER_MD_EN
               if (md_req) begin
                  sel_d   = md_sel;
                  neg_d   = neg_init;
                  acc_d   = {{XLEN{1'b0}}, ma};
                  opb_d   = mb;
                  cnt_d   = CW'(XLEN);
                  state_d = S_BUSY;
               end else begin
                  res_d   = base_res;
                  state_d = S_DONE;
               end
`else
               res_d   = base_res;
               state_d = S_DONE;
`endif
            end
`ifdef ALU_MD_ITER_MD_EN
            S_BUSY: begin
               acc_d = acc_nx;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  res_d   = md_res;
                  state_d = S_DONE;
               end
            end
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
      end
   end

`ifdef ALU_MD_ITER_MD_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
         sel_q <= '0;
         neg_q <= 1'b0;
         acc_q <= '0;
         opb_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
         neg_q <= neg_d;
         acc_q <= acc_d;
         opb_q <= opb_d;
      end
   end
`endif
endmodule

// File: tb/tb_alu_md_iter.sv
// Self-checking bench for alu_md_iter (XLEN=32): vector table, handshake and
// flush/reset corner sequences, then random ops against a behavioural model.
module tb_alu_md_iter;
   localparam int XLEN = 32;
`ifdef ALU_MD_ITER_MD_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int MDL = MD ? XLEN + 1 : 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   alu_md_iter_if #(.XLEN(XLEN)) bus ();
   alu_md_iter #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .flush(flush), .bus(bus));

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       nm;
      logic [18:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [18:0] bit_op(input int k);
      return 19'(1) << k;
   endfunction

   // Reference: mul/div from 64-bit arithmetic, base ops from plain operators.
   function automatic logic [31:0] model(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint p;
      logic [63:0] pv, up;
      logic [31:0] r;
      bit ovf;
      sa = a; sb = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (MD && (op[18:12] != 0)) begin
         p  = longint'(sa) * longint'(sb);
         pv = p;
         up = {32'b0, a} * {32'b0, b};
         if (op[12]) return pv[31:0];
         if (op[13]) return pv[63:32];
         if (op[14]) return up[63:32];
         if (op[15]) return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         if (op[16]) return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         if (op[17]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
         return (b == 0) ? a : a % b;
      end
      r = 0;
      if (op[0])  r |= a + b;
      if (op[1])  r |= a - b;
      if (op[2])  r |= (sa < sb) ? 32'd1 : 32'd0;
      if (op[3])  r |= (a < b) ? 32'd1 : 32'd0;
      if (op[4])  r |= a & b;
      if (op[5])  r |= ~(a | b);
      if (op[6])  r |= a | b;
      if (op[7])  r |= a ^ b;
      if (op[8])  r |= a << b[4:0];
      if (op[9])  r |= a >> b[4:0];
      if (op[10]) r |= 32'(sa >>> b[4:0]);
      if (op[11]) r |= b;
      return r;
   endfunction

   function automatic int model_lat(input logic [18:0] op);
      return (MD && (op[18:12] != 0)) ? XLEN + 1 : 1;
   endfunction

   task automatic wait_ready(input string nm);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) chk({nm, " ready timeout"}, 0, 1);
   endtask

   task automatic run(input string nm, input logic [18:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
      int lat;
      wait_ready(nm);
      bus.in_valid = 1'b1; bus.alu_op = op; bus.alu_src1 = a; bus.alu_src2 = b;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'(lat_exp));
      chk({nm, " result"}, bus.alu_result, exp);
   endtask

   // Watch for any out_valid over n cycles; there must be none.
   task automatic no_pulse(input string nm, input int n);
      bit seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1;
      end
      chk({nm, " no out_valid"}, seen, 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] tmp, ra, rb;
      logic [18:0] rop;

      tbl.push_back('{"add wrap", bit_op(0), 32'hFFFF_FFFF, 32'h1, 32'h0, 1});
      tbl.push_back('{"sra", bit_op(10), 32'h8000_0000, 32'h4, 32'hF800_0000, 1});
      tbl.push_back('{"sub", bit_op(1), 32'h5, 32'h7, 32'hFFFF_FFFE, 1});
      tbl.push_back('{"slt", bit_op(2), 32'hFFFF_FFFF, 32'h1, 32'h1, 1});
      tbl.push_back('{"sltu", bit_op(3), 32'hFFFF_FFFF, 32'h1, 32'h0, 1});
      tbl.push_back('{"and", bit_op(4), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1});
      tbl.push_back('{"nor", bit_op(5), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1});
      tbl.push_back('{"or", bit_op(6), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1});
      tbl.push_back('{"xor", bit_op(7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1});
      tbl.push_back('{"sll trunc", bit_op(8), 32'h1, 32'd33, 32'h2, 1});
      tbl.push_back('{"srl", bit_op(9), 32'h8000_0000, 32'd31, 32'h1, 1});
      tbl.push_back('{"lui", bit_op(11), 32'h0, 32'h1234_5000, 32'h1234_5000, 1});
      tbl.push_back('{"add|and", bit_op(0) | bit_op(4), 32'h3, 32'h1, 32'h5, 1});
      tbl.push_back('{"op zero", 19'h0, 32'h1234, 32'h5678, 32'h0, 1});
      tbl.push_back('{"mulh", bit_op(13), 32'hFFFF_FFFE, 32'h3, MD ? 32'hFFFF_FFFF : 32'h0, MDL});
      tbl.push_back('{"mul", bit_op(12), 32'hFFFF_FFFE, 32'h3, MD ? 32'hFFFF_FFFA : 32'h0, MDL});
      tbl.push_back('{"mulhu", bit_op(14), 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'hFFFF_FFFE : 32'h0, MDL});
      tbl.push_back('{"div ovf", bit_op(15), 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'h0, MDL});
      tbl.push_back('{"mod ovf", bit_op(16), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, MDL});
      tbl.push_back('{"divu by0", bit_op(17), 32'h7, 32'h0, MD ? 32'hFFFF_FFFF : 32'h0, MDL});
      tbl.push_back('{"modu by0", bit_op(18), 32'h7, 32'h0, MD ? 32'h7 : 32'h0, MDL});
      tbl.push_back('{"div neg", bit_op(15), 32'hFFFF_FFF9, 32'h2, MD ? 32'hFFFF_FFFD : 32'h0, MDL});
      tbl.push_back('{"mod neg", bit_op(16), 32'hFFFF_FFF9, 32'h2, MD ? 32'hFFFF_FFFF : 32'h0, MDL});
      tbl.push_back('{"div neg by0", bit_op(15), 32'hFFFF_FFF9, 32'h0, MD ? 32'hFFFF_FFFF : 32'h0, MDL});
      tbl.push_back('{"mod neg by0", bit_op(16), 32'hFFFF_FFF9, 32'h0, MD ? 32'hFFFF_FFF9 : 32'h0, MDL});
      tbl.push_back('{"mul|add", bit_op(12) | bit_op(0), 32'h3, 32'h4, MD ? 32'hC : 32'h7, 1 + (MDL - 1)});
      tbl.push_back('{"divu|mod", bit_op(17) | bit_op(16), 32'hFFFF_FFF9, 32'h2, MD ? 32'hFFFF_FFFF : 32'h0, MDL});

      bus.in_valid = 1'b0; bus.alu_op = '0; bus.alu_src1 = '0; bus.alu_src2 = '0;
      bus.out_ready = 1'b0;

      // Reset held two cycles.
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset result", bus.alu_result, 0);
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset busy", bus.busy, 0);
      @(negedge clk);
      resetn = 1'b1;

      foreach (tbl[i]) run(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

      // Backpressure: result held while out_ready is low.
      wait_ready("bp");
      bus.in_valid = 1'b1; bus.alu_op = bit_op(3); bus.alu_src1 = 32'd1; bus.alu_src2 = 32'd2;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp first valid", bus.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d valid", i), bus.out_valid, 1);
         chk($sformatf("bp hold%0d result", i), bus.alu_result, 1);
         chk($sformatf("bp hold%0d in_ready", i), bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release valid", bus.out_valid, 0);
      chk("bp release in_ready", bus.in_ready, 1);

      // Accept in the same cycle as flush is dropped; result keeps its last value.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.alu_op = bit_op(0); bus.alu_src1 = 32'd9; bus.alu_src2 = 32'd9;
      flush = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; flush = 1'b0;
      chk("flush accept in_ready", bus.in_ready, 1);
      chk("flush accept result kept", bus.alu_result, 1);
      no_pulse("flush accept", 3);

      // Flush while DONE is stalled.
      wait_ready("flush done");
      bus.in_valid = 1'b1; bus.alu_op = bit_op(7); bus.alu_src1 = 32'hA5; bus.alu_src2 = 32'h0F;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("flush done valid", bus.out_valid, 1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush done cleared", bus.out_valid, 0);
      chk("flush done result kept", bus.alu_result, 32'hAA);
      bus.out_ready = 1'b1;

`ifdef ALU_MD_ITER_MD_EN
      // Flush in the tenth cycle of a divide.
      wait_ready("flush busy");
      bus.in_valid = 1'b1; bus.alu_op = bit_op(17); bus.alu_src1 = 32'd100; bus.alu_src2 = 32'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("divu busy", bus.busy, 1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush busy busy", bus.busy, 0);
      chk("flush busy in_ready", bus.in_ready, 1);
      no_pulse("flush busy", 40);
      run("add after flush", bit_op(0), 32'd2, 32'd3, 32'd5, 1);

      // Reset in the middle of a divide.
      wait_ready("reset busy");
      bus.in_valid = 1'b1; bus.alu_op = bit_op(15); bus.alu_src1 = 32'd1000; bus.alu_src2 = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("reset busy busy", bus.busy, 0);
      chk("reset busy result", bus.alu_result, 0);
      chk("reset busy in_ready", bus.in_ready, 1);
      no_pulse("reset busy", 40);
      run("add after reset", bit_op(0), 32'd2, 32'd3, 32'd5, 1);
`else
      wait_ready("no md busy");
      bus.in_valid = 1'b1; bus.alu_op = bit_op(15); bus.alu_src1 = 32'd10; bus.alu_src2 = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("no md busy", bus.busy, 0);
      chk("no md valid", bus.out_valid, 1);
      run("add after no md", bit_op(0), 32'd2, 32'd3, 32'd5, 1);
`endif

      // Random ops against the model.
      for (int i = 0; i < 150; i++) begin
         tmp = $urandom;
         rop = ($urandom_range(0, 9) == 0) ? tmp[18:0] : bit_op($urandom_range(0, 18));
         case ($urandom_range(0, 5))
            0: ra = 32'h0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = $urandom_range(1, 40);
            default: rb = $urandom;
         endcase
         run($sformatf("rnd%0d op=%0h a=%0h b=%0h", i, rop, ra, rb), rop, ra, rb,
             model(rop, ra, rb), model_lat(rop));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_md_iter.md
Name: alu_md_iter

Overview:
- Parametrised-width successor of the single-cycle ALU for the execute stage.
- Adds registered output, a valid/ready handshake on both sides, and an iterative multiply/divide path.
- Single-cycle ops return one cycle after acceptance. Multiply/divide occupy the unit for XLEN iterations.
- A pipeline flush cancels the operation in flight.

Parameters:
- XLEN, 32, operand and result width; power of two, 8 to 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- flush  input  1  cancel any op in flight; drop the pending result.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_op  input  19  one-hot op select.
  - Bits 0-11: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Bits 12-18: mul, mulh, mulhu, div, mod, divu, modu.
- alu_src1  input  XLEN  operand 1 (rj).
- alu_src2  input  XLEN  operand 2 (rk or immediate).
- out_valid  output  1  alu_result holds a completed result.
- out_ready  input  1  consumer takes the result.
- alu_result  output  XLEN  registered result.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (resetn low at a clk edge):
  - State goes to IDLE.
  - out_valid=0, alu_result=0, busy=0, in_ready=1, iteration counter=0.
  - Reset overrides flush and the handshakes.
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready.
- IDLE, accept of op bits 0-11:
  - Result is computed combinationally and registered.
  - Next state DONE; out_valid=1 the next cycle (latency 1).
- Base-op semantics:
  - add/sub: modulo 2^XLEN.
  - slt: signed less-than, result 0 or 1. sltu: unsigned less-than, result 0 or 1.
  - sll/srl/sra: shift by src2[SHW-1:0]; sra sign-fills.
  - lui: result = alu_src2; the decoder supplies the pre-positioned immediate.
- IDLE, accept of op bits 12-18:
  - Operands and op are latched; counter loads XLEN; next state BUSY.
  - mul/mulh: signed × signed, 2·XLEN-bit product via shift-add on magnitudes plus sign fix-up.
  - mul returns the low XLEN bits; mulh the signed high XLEN bits; mulhu the unsigned high XLEN bits.
  - div/mod: signed restoring division on magnitudes. Quotient truncates toward zero; remainder takes the dividend's sign.
  - divu/modu: unsigned restoring division.
- BUSY:
  - One iteration per cycle; counter decrements.
  - When counter=1, the final iteration completes and the result is registered; next state DONE.
  - Accepted at cycle N, out_valid=1 at cycle N+XLEN+1.
- DONE:
  - out_valid=1 and alu_result stays stable until out_ready=1.
  - On out_ready=1, next state IDLE and out_valid=0.
  - The next accept can happen in the cycle after DONE, not the same cycle.
- Divide by zero:
  - div/divu: quotient all-ones.
  - mod/modu: remainder = dividend.
  - Still takes the full XLEN+1 latency.
- Signed overflow (dividend = -2^(XLEN-1), divisor = -1): div returns -2^(XLEN-1); mod returns 0.
- Multi-bit alu_op:
  - If any bit 12-18 is set, the lowest set mul/div bit is executed and bits 0-11 are ignored.
  - Otherwise the base results of all set bits are OR-ed.
  - alu_op = 0 gives result 0.
- flush=1:
  - From any state, next state IDLE, out_valid=0, counter=0.
  - An accept in the same cycle as flush is discarded.
  - alu_result keeps its last value.

Optional Feature:
- Macro ALU_MD_ITER_MD_EN.
- When defined: mul/div path, BUSY state and counter are present, as above.
- When undefined:
  - Bits 12-18 are ignored; the unit only ever uses IDLE to DONE.
  - An op with only mul/div bits set returns 0 with latency 1.
  - busy is tied to 0.

Test Plan:
- Reset with resetn=0 for 2 cycles → out_valid=0, alu_result=0, in_ready=1, busy=0.
- add 0xFFFFFFFF+0x00000001, out_ready=1 → out_valid exactly 1 cycle later, alu_result=0x00000000; then sra 0x80000000 by 4 → 0xF8000000.
- mulh 0xFFFFFFFE×0x00000003 (−2×3) → out_valid at accept+33; alu_result=0xFFFFFFFF; then mul gives 0xFFFFFFFA.
- div 0x80000000/0xFFFFFFFF → 0x80000000 and mod → 0; divu 7/0 → 0xFFFFFFFF; modu 7/0 → 0x00000007.
- Backpressure: out_ready=0 for 5 cycles after a sltu 1<2 → out_valid stays 1, alu_result=1 stable, in_ready=0; out_ready=1 → IDLE next cycle.
- flush at cycle 10 of a divu, and a separate case with resetn=0 mid-BUSY → IDLE next cycle, no out_valid pulse, following add 2+3 returns 5 with latency 1.
